mem_uart_responder: RTL

Far-end responder for the byte-serial memory protocol spoken by the UART memory controller. Sits between a UART receiver/transmitter pair and a word-wide memory port. Decodes read/write command frames from the RX byte stream, reassembles the 7-bit-segmented address and data, performs one memory access per frame, and returns read data on the TX byte stream.

---
 rtl/mem_uart_responder_pkg.sv | 42 ++++
 rtl/mem_uart_responder_if.sv | 33 +++
 rtl/mem_uart_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_uart_responder_pkg.sv
// Shared constants, state encoding and field-packing helpers for the
// byte-serial memory responder.
package mem_uart_responder_pkg;

    localparam logic [7:0] CMD_RD  = 8'hC0;
    localparam logic [7:0] CMD_WR  = 8'h80;
    localparam int         CMD_BIT = 7;
    localparam int         RD_BIT  = 6;
    localparam int         SEG_W   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AMSB,
        ST_LEN,
        ST_WDATA,
        ST_WMSB,
        ST_MEM,
        ST_RESP
    } state_t;

    // Fields arrive as 7-bit segments followed by one byte of bit-7 values.
    function automatic logic [31:0] insert_seg(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [SEG_W-1:0] seg);
        return word | ({25'b0, seg} << {idx, 3'b000});
    endfunction

    function automatic logic [31:0] spread_msb(input logic [3:0] bits);
        return {bits[3], 7'b0, bits[2], 7'b0, bits[1], 7'b0, bits[0], 7'b0};
    endfunction

    function automatic logic [3:0] be_mask(input logic [1:0] len);
        case (len)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_uart_responder_if.sv
// Byte-stream and memory-port signals of the responder; the slave modport
// is the responder's view, the master modport the surrounding system's.
interface mem_uart_responder_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        frame_err;
    logic        busy;

    modport master (
        output rx_data, rx_valid, tx_ready, mem_rdata, mem_ack,
        input  rx_ready, tx_data, tx_valid, mem_req, mem_we, mem_addr,
               mem_wdata, mem_be, frame_err, busy
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready, mem_rdata, mem_ack,
        output rx_ready, tx_data, tx_valid, mem_req, mem_we, mem_addr,
               mem_wdata, mem_be, frame_err, busy
    );

endinterface

// File: rtl/mem_uart_responder.sv
// Far-end responder: decodes read/write command frames from the RX byte
// stream, performs one memory access per frame and returns read data on TX.
module mem_uart_responder
    import mem_uart_responder_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input logic                 clk,
    input logic                 rst,
    mem_uart_responder_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic [1:0]        len, len_n;
    logic              is_read, is_read_n;
    logic [31:0]       addr, addr_n;
    logic [31:0]       wdata, wdata_n;
    logic [31:0]       rdata, rdata_n;
    logic [TMO_W-1:0]  tmo, tmo_n;
    logic              err_q, err_n;

    logic rx_ready_int;
    logic beat;
    logic in_frame;
    logic cmd_byte;

    assign rx_ready_int = (state != ST_MEM) && (state != ST_RESP);
    assign beat         = bus.rx_valid && rx_ready_int;
    assign in_frame     = rx_ready_int && (state != ST_IDLE);
    assign cmd_byte     = (bus.rx_data == CMD_RD) || (bus.rx_data == CMD_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            len     <= '0;
            is_read <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            rdata   <= '0;
            tmo     <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            len     <= len_n;
            is_read <= is_read_n;
            addr    <= addr_n;
            wdata   <= wdata_n;
            rdata   <= rdata_n;
            tmo     <= tmo_n;
            err_q   <= err_n;
        end
    end

    // Any bit-7 byte inside a frame restarts decoding, as does every byte in IDLE.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        len_n     = len;
        is_read_n = is_read;
        addr_n    = addr;
        wdata_n   = wdata;
        rdata_n   = rdata;
        tmo_n     = '0;
        err_n     = 1'b0;

        if (beat && ((state == ST_IDLE) || bus.rx_data[CMD_BIT])) begin
            err_n = (state != ST_IDLE) || !cmd_byte;
            if (cmd_byte) begin
                is_read_n = bus.rx_data[RD_BIT];
                addr_n    = '0;
                wdata_n   = '0;
                cnt_n     = '0;
                len_n     = '0;
                state_n   = ST_ADDR;
            end else begin
                state_n = ST_IDLE;
            end
        end else if (beat) begin
            case (state)
                ST_ADDR: begin
                    addr_n = insert_seg(addr, cnt, bus.rx_data[SEG_W-1:0]);
                    cnt_n  = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_n = ST_AMSB;
                    end
                end
                ST_AMSB: begin
                    if (bus.rx_data[7:4] != 4'b0) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        addr_n  = addr | spread_msb(bus.rx_data[3:0]);
                        state_n = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (bus.rx_data[7:2] != 6'b0) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        len_n   = bus.rx_data[1:0];
                        cnt_n   = '0;
                        state_n = is_read ? ST_MEM : ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    wdata_n = insert_seg(wdata, cnt, bus.rx_data[SEG_W-1:0]);
                    if (cnt == len) begin
                        cnt_n   = '0;
                        state_n = ST_WMSB;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
                ST_WMSB: begin
                    if ((bus.rx_data[7:4] != 4'b0) ||
                        ((bus.rx_data[3:0] & ~be_mask(len)) != 4'b0)) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        wdata_n = wdata | spread_msb(bus.rx_data[3:0]);
                        state_n = ST_MEM;
                    end
                end
                default: ;
            endcase
        end else if (in_frame) begin
            if (tmo == TMO_W'(TIMEOUT - 1)) begin
                err_n   = 1'b1;
                state_n = ST_IDLE;
            end else begin
                tmo_n = tmo + 1'b1;
            end
        end else if (state == ST_MEM) begin
            if (bus.mem_ack) begin
                if (is_read) begin
                    rdata_n = bus.mem_rdata;
                    cnt_n   = '0;
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_IDLE;
                end
            end
        end else if (state == ST_RESP) begin
            if (bus.tx_ready) begin
                if (cnt == len) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
        end
    end

    assign bus.rx_ready  = rx_ready_int;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.frame_err = err_q;
    assign bus.mem_req   = (state == ST_MEM);
    assign bus.mem_we    = (state == ST_MEM) && !is_read;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_be    = (state == ST_MEM) ? be_mask(len) : 4'b0;
    assign bus.tx_valid  = (state == ST_RESP);
    assign bus.tx_data   = (state == ST_RESP) ? rdata[{cnt, 3'b000} +: 8] : 8'h00;

endmodule
